gecko_reg_scoreboard: RTL and testbench
=======================================

// Module: gecko_reg_scoreboard
// PURPOSE
//   Decode-side issue controller for the register writeback ordering scheme.
//   - Assigns each issued instruction's destination register its reg_status tag.
//   - Flags outstanding (not yet written back) source registers.
//   - Stalls issue when a register's tag space is exhausted.
//   Sits between decode and the execute/memory/system units. Retires tags by
//   observing every result accepted on the writeback output stream.
// PARAMETERS
//   NUM_REGS      32  architectural registers tracked; x0 never tracked
//   ADDR_WIDTH    5   register address width; $clog2(NUM_REGS)
//   STATUS_WIDTH  2   tag width; equals $size(gecko_reg_status_t); must be >= 2
// PORTS
//   clk             in   1             clock
//   rst             in   1             synchronous reset, ACTIVE-LOW (rst==0 resets)
//   issue_valid     in   1             decode presents an instruction
//   issue_ready     out  1             scoreboard accepts it this cycle
//   issue_rd_write  in   1             instruction writes rd
//   issue_rd_addr   in   ADDR_WIDTH    destination register
//   issue_rs1_addr  in   ADDR_WIDTH    source register 1
//   issue_rs2_addr  in   ADDR_WIDTH    source register 2
//   issue_rd_status out  STATUS_WIDTH  tag to carry as reg_status with rd's result
//   rs1_pending     out  1             rs1 has outstanding writes
//   rs2_pending     out  1             rs2 has outstanding writes
//   wb_valid        in   1             writeback output handshake fired (valid&&ready)
//   wb_addr         in   ADDR_WIDTH    addr of retired result
//   wb_status       in   STATUS_WIDTH  reg_status of retired result
//   init_done       out  1             reset sweep complete
//   protocol_error  out  1             sticky: out-of-order or spurious retire seen
// BEHAVIOUR
//   - State per register r: issue_ctr[r] (next tag) and retire_ctr[r] (next expected
//     retire tag), both STATUS_WIDTH.
//   - outstanding[r] = issue_ctr[r] - retire_ctr[r], modulo 2^STATUS_WIDTH.
//   - Reset (rst==0, sync): enter INIT. Outputs during INIT:
//     issue_ready=0, init_done=0, protocol_error=0, pendings=0, issue_rd_status=0.
//   - INIT: sweep counter clears one register's issue_ctr and retire_ctr per cycle,
//     addresses 0..NUM_REGS-1. Wraps to 0, then enters RUN; init_done=1 from the
//     following cycle. INIT lasts NUM_REGS cycles. wb_valid is ignored in INIT.
//   - RUN, outputs (all combinational from registered state, no same-cycle bypass):
//     - issue_rd_status = issue_ctr[rd].
//     - rsN_pending = (rsN != 0) && outstanding[rsN] != 0.
//     - issue_ready = !(issue_rd_write && rd != 0 &&
//       outstanding[rd] == 2^STATUS_WIDTH-1).
//     - issue_ready must not depend on issue_valid.
//   - Issue fire (valid && ready && rd_write && rd != 0): issue_ctr[rd]++ at clk edge.
//   - x0: rd==0 never allocates and reports tag 0. rs==0 never pending.
//   - Retire (wb_valid in RUN, wb_addr != 0):
//     - If wb_status == retire_ctr[wb_addr] and outstanding != 0: retire_ctr++.
//     - Otherwise: no counter change; protocol_error set, held until reset.
//     - wb_addr==0 is ignored.
//   - Simultaneous issue and retire on the same register: both counters update in
//     one edge. Outputs that cycle reflect pre-edge state, so pending stays 1 and a
//     full rd stays stalled for that cycle.
//   - rd == rs1/rs2 in one instruction: pending is evaluated before rd's allocation.
//   - Wrap-around: counters wrap mod 2^STATUS_WIDTH. Saturation cap guarantees
//     tags are unambiguous.
//   - Reset mid-RUN: all in-flight state dropped and INIT restarts. Downstream
//     units are reset in the same cycle.
// STRUCTURE
//   - gecko package: add gecko_scoreboard_state_t (INIT, RUN) and
//     GECKO_REG_STATUS_WIDTH = $size(gecko_reg_status_t).
//   - STATIC_ASSERT: NUM_REGS == 2**ADDR_WIDTH.
//   - Sub-module gecko_reg_status_table: NUM_REGS x STATUS_WIDTH flop array with
//     3 async read ports, 1 increment port, and a clear port. Instantiated twice
//     (issue, retire). Top level holds the FSM, sweep counter and compare logic.
// TESTING
//   - Reset: hold rst=0 3 cycles, release -> issue_ready=0 for exactly 32 cycles,
//     then init_done=1, issue_ready=1.
//   - Issue rd=5 three times -> tags 0,1,2. rs1=5 next -> rs1_pending=1.
//     Retire (5,0),(5,1),(5,2) -> rs1_pending=0.
//   - STATUS_WIDTH=2, issue rd=7 x3 -> 4th attempt issue_ready=0. Retire (7,0)
//     -> ready=1 next cycle, 4th tag=3. Continue to wrap: tag 0 reissued.
//   - rd=0 with rd_write=1, issued 10x -> ready always 1, tag 0. rs1=0 never pending.
//   - Same cycle: issue rd=9 and retire (9,0) with 1 outstanding -> outstanding
//     stays 1, issue_ctr[9]=2, retire_ctr[9]=1.
//   - Retire (4,1) when retire_ctr[4]=0 -> protocol_error=1 sticky, counters
//     unchanged. rst=0 mid-stream -> error cleared, INIT repeats 32 cycles.

Source files
------------

// File: rtl/gecko_reg_scoreboard_pkg.sv
// Shared types and constants for the register writeback-ordering scoreboard.
package gecko_reg_scoreboard_pkg;

    // Tag carried with every result so writebacks to one register retire in order.
    typedef logic [1:0] gecko_reg_status_t;

    localparam int GECKO_REG_STATUS_WIDTH = $bits(gecko_reg_status_t);
    localparam int GECKO_NUM_REGS         = 32;
    localparam int GECKO_ADDR_WIDTH       = 5;

    // INIT sweeps the counter tables clean; RUN is normal issue/retire operation.
    typedef enum logic {
        GECKO_SB_INIT = 1'b0,
        GECKO_SB_RUN  = 1'b1
    } gecko_scoreboard_state_t;

endpackage

// File: rtl/gecko_reg_scoreboard_status_table.sv
// Per-register tag counter table: NUM_REGS counters of STATUS_WIDTH bits with
// several asynchronous read ports, one increment port and one clear port.
// Two copies back the scoreboard: one counts issued tags, one counts retired tags.
module gecko_reg_status_table
    import gecko_reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS     = GECKO_NUM_REGS,
    parameter int ADDR_WIDTH   = GECKO_ADDR_WIDTH,
    parameter int STATUS_WIDTH = GECKO_REG_STATUS_WIDTH,
    parameter int NUM_RD_PORTS = 3
) (
    input  logic                                      clk_i,
    input  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [NUM_RD_PORTS-1:0][STATUS_WIDTH-1:0] rd_data_o,
    input  logic                                      inc_en_i,
    input  logic [ADDR_WIDTH-1:0]                     inc_addr_i,
    input  logic                                      clr_en_i,
    input  logic [ADDR_WIDTH-1:0]                     clr_addr_i
);

    logic [STATUS_WIDTH-1:0] table_q [NUM_REGS];
    logic [STATUS_WIDTH-1:0] table_d [NUM_REGS];

    // Next table contents: increment wraps naturally, a clear on the same entry wins.
    always_comb begin
        table_d = table_q;
        if (inc_en_i) begin
            table_d[inc_addr_i] = table_q[inc_addr_i] + STATUS_WIDTH'(1);
        end
        if (clr_en_i) begin
            table_d[clr_addr_i] = '0;
        end
    end

    // Counter storage; no reset here because the owner's INIT sweep clears every entry.
    always_ff @(posedge clk_i) begin
        table_q <= table_d;
    end

    // Asynchronous read ports straight off the flops, no write-through bypass.
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_port
        assign rd_data_o[p] = table_q[rd_addr_i[p]];
    end

endmodule

// File: rtl/gecko_reg_scoreboard.sv
// Decode-side issue controller: hands out per-register writeback tags, flags
// source registers with writes still in flight, stalls when a register's tag
// space is full, and retires tags by watching the accepted writeback stream.
module gecko_reg_scoreboard
    import gecko_reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS     = GECKO_NUM_REGS,
    parameter int ADDR_WIDTH   = GECKO_ADDR_WIDTH,
    parameter int STATUS_WIDTH = GECKO_REG_STATUS_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic                    issue_rd_write,
    input  logic [ADDR_WIDTH-1:0]   issue_rd_addr,
    input  logic [ADDR_WIDTH-1:0]   issue_rs1_addr,
    input  logic [ADDR_WIDTH-1:0]   issue_rs2_addr,
    output logic [STATUS_WIDTH-1:0] issue_rd_status,
    output logic                    rs1_pending,
    output logic                    rs2_pending,
    input  logic                    wb_valid,
    input  logic [ADDR_WIDTH-1:0]   wb_addr,
    input  logic [STATUS_WIDTH-1:0] wb_status,
    output logic                    init_done,
    output logic                    protocol_error
);

    // Elaboration-time configuration checks.
    if (NUM_REGS != (2 ** ADDR_WIDTH)) begin : g_bad_num_regs
        $error("gecko_reg_scoreboard: NUM_REGS must equal 2**ADDR_WIDTH");
    end
    if (STATUS_WIDTH < 2) begin : g_bad_status_width
        $error("gecko_reg_scoreboard: STATUS_WIDTH must be at least 2");
    end

    // Read port map shared by both tables: rd, rs1, rs2 and the retiring address.
    localparam int NUM_RD_PORTS = 4;
    localparam int RP_RD        = 0;
    localparam int RP_RS1       = 1;
    localparam int RP_RS2       = 2;
    localparam int RP_WB        = 3;

    localparam logic [STATUS_WIDTH-1:0] STATUS_FULL = '1;
    localparam logic [STATUS_WIDTH-1:0] STATUS_NONE = '0;
    localparam logic [ADDR_WIDTH-1:0]   ADDR_X0     = '0;
    localparam logic [ADDR_WIDTH-1:0]   SWEEP_LAST  = ADDR_WIDTH'(NUM_REGS - 1);

    gecko_scoreboard_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
    logic                    protoErr_q, protoErr_d;

    logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0]   tableAddr;
    logic [NUM_RD_PORTS-1:0][STATUS_WIDTH-1:0] issueCtr;
    logic [NUM_RD_PORTS-1:0][STATUS_WIDTH-1:0] retireCtr;

    logic [STATUS_WIDTH-1:0] rdOutstanding;
    logic [STATUS_WIDTH-1:0] rs1Outstanding;
    logic [STATUS_WIDTH-1:0] rs2Outstanding;
    logic [STATUS_WIDTH-1:0] wbOutstanding;

    logic inRun;
    logic clearEn;
    logic rdFull;
    logic issueFire;
    logic wbSeen;
    logic wbMatch;
    logic retireFire;
    logic retireBad;

    assign tableAddr[RP_RD]  = issue_rd_addr;
    assign tableAddr[RP_RS1] = issue_rs1_addr;
    assign tableAddr[RP_RS2] = issue_rs2_addr;
    assign tableAddr[RP_WB]  = wb_addr;

    // Next tag to hand out for each register.
    gecko_reg_status_table #(
        .NUM_REGS     (NUM_REGS),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .STATUS_WIDTH (STATUS_WIDTH),
        .NUM_RD_PORTS (NUM_RD_PORTS)
    ) u_issue_table (
        .clk_i      (clk),
        .rd_addr_i  (tableAddr),
        .rd_data_o  (issueCtr),
        .inc_en_i   (issueFire),
        .inc_addr_i (issue_rd_addr),
        .clr_en_i   (clearEn),
        .clr_addr_i (sweep_q)
    );

    // Next tag expected back on the writeback stream for each register.
    gecko_reg_status_table #(
        .NUM_REGS     (NUM_REGS),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .STATUS_WIDTH (STATUS_WIDTH),
        .NUM_RD_PORTS (NUM_RD_PORTS)
    ) u_retire_table (
        .clk_i      (clk),
        .rd_addr_i  (tableAddr),
        .rd_data_o  (retireCtr),
        .inc_en_i   (retireFire),
        .inc_addr_i (wb_addr),
        .clr_en_i   (clearEn),
        .clr_addr_i (sweep_q)
    );

    // Writes in flight per register; modular difference is exact because the
    // stall below never lets it reach 2^STATUS_WIDTH.
    assign rdOutstanding  = issueCtr[RP_RD]  - retireCtr[RP_RD];
    assign rs1Outstanding = issueCtr[RP_RS1] - retireCtr[RP_RS1];
    assign rs2Outstanding = issueCtr[RP_RS2] - retireCtr[RP_RS2];
    assign wbOutstanding  = issueCtr[RP_WB]  - retireCtr[RP_WB];

    assign inRun   = (state_q == GECKO_SB_RUN);
    assign clearEn = (state_q == GECKO_SB_INIT);

    // Stall is a function of the request only, never of issue_valid.
    assign rdFull    = issue_rd_write && (issue_rd_addr != ADDR_X0) &&
                       (rdOutstanding == STATUS_FULL);
    assign issueFire = inRun && issue_valid && !rdFull &&
                       issue_rd_write && (issue_rd_addr != ADDR_X0);

    // A retire is legal only if it carries the oldest outstanding tag of its register.
    assign wbSeen     = inRun && wb_valid && (wb_addr != ADDR_X0);
    assign wbMatch    = (wb_status == retireCtr[RP_WB]) && (wbOutstanding != STATUS_NONE);
    assign retireFire = wbSeen && wbMatch;
    assign retireBad  = wbSeen && !wbMatch;

    // State, sweep pointer and sticky error flop; active-low synchronous reset restarts INIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= GECKO_SB_INIT;
            sweep_q    <= '0;
            protoErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            protoErr_q <= protoErr_d;
        end
    end

    // Next state: sweep every register once, then run; latch any bad retire.
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        protoErr_d = protoErr_q;
        case (state_q)
            GECKO_SB_INIT: begin
                sweep_d = sweep_q + ADDR_WIDTH'(1);
                if (sweep_q == SWEEP_LAST) begin
                    state_d = GECKO_SB_RUN;
                end
            end
            GECKO_SB_RUN: begin
                sweep_d = '0;
                if (retireBad) begin
                    protoErr_d = 1'b1;
                end
            end
            default: begin
                state_d = GECKO_SB_INIT;
                sweep_d = '0;
            end
        endcase
    end

    // Outputs: everything held quiet during INIT, derived from pre-edge state in RUN.
    always_comb begin
        issue_ready     = 1'b0;
        issue_rd_status = '0;
        rs1_pending     = 1'b0;
        rs2_pending     = 1'b0;
        init_done       = 1'b0;
        protocol_error  = 1'b0;
        if (inRun) begin
            issue_ready     = !rdFull;
            issue_rd_status = (issue_rd_addr != ADDR_X0) ? issueCtr[RP_RD] : STATUS_NONE;
            rs1_pending     = (issue_rs1_addr != ADDR_X0) && (rs1Outstanding != STATUS_NONE);
            rs2_pending     = (issue_rs2_addr != ADDR_X0) && (rs2Outstanding != STATUS_NONE);
            init_done       = 1'b1;
            protocol_error  = protoErr_q;
        end
    end

endmodule

// File: tb/tb_gecko_reg_scoreboard.sv
// Self-checking bench for gecko_reg_scoreboard: directed scenarios plus random
// traffic, all compared against an unbounded issue/retire count model.
module tb_gecko_reg_scoreboard;

    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int SW   = 2;
    localparam int TAGS = 4;

    logic          clk;
    logic          rst;
    logic          issue_valid;
    logic          issue_ready;
    logic          issue_rd_write;
    logic [AW-1:0] issue_rd_addr;
    logic [AW-1:0] issue_rs1_addr;
    logic [AW-1:0] issue_rs2_addr;
    logic [SW-1:0] issue_rd_status;
    logic          rs1_pending;
    logic          rs2_pending;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [SW-1:0] wb_status;
    logic          init_done;
    logic          protocol_error;

    int vectorCount;
    int missCount;

    // Reference model: total issues and retires per register, never wrapped.
    int issuedCnt  [NR];
    int retiredCnt [NR];
    bit modelErr;

    gecko_reg_scoreboard #(
        .NUM_REGS     (NR),
        .ADDR_WIDTH   (AW),
        .STATUS_WIDTH (SW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_rd_write  (issue_rd_write),
        .issue_rd_addr   (issue_rd_addr),
        .issue_rs1_addr  (issue_rs1_addr),
        .issue_rs2_addr  (issue_rs2_addr),
        .issue_rd_status (issue_rd_status),
        .rs1_pending     (rs1_pending),
        .rs2_pending     (rs2_pending),
        .wb_valid        (wb_valid),
        .wb_addr         (wb_addr),
        .wb_status       (wb_status),
        .init_done       (init_done),
        .protocol_error  (protocol_error)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, report it if it differs.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed != expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(input bit v, input bit w, input int rd, input int rs1,
                                 input int rs2, input bit wbV, input int wbA, input int wbS);
        bit expReady;
        bit retireOk;
        bit retireBad;
        issue_valid    = v;
        issue_rd_write = w;
        issue_rd_addr  = AW'(rd);
        issue_rs1_addr = AW'(rs1);
        issue_rs2_addr = AW'(rs2);
        wb_valid       = wbV;
        wb_addr        = AW'(wbA);
        wb_status      = SW'(wbS);
        @(negedge clk);
        expReady = !(w && rd != 0 && (issuedCnt[rd] - retiredCnt[rd]) == TAGS - 1);
        checkOutput("issue_ready", int'(issue_ready), int'(expReady));
        checkOutput("rd_status", int'(issue_rd_status), (rd == 0) ? 0 : issuedCnt[rd] % TAGS);
        checkOutput("rs1_pending", int'(rs1_pending),
                    int'(rs1 != 0 && issuedCnt[rs1] != retiredCnt[rs1]));
        checkOutput("rs2_pending", int'(rs2_pending),
                    int'(rs2 != 0 && issuedCnt[rs2] != retiredCnt[rs2]));
        checkOutput("init_done", int'(init_done), 1);
        checkOutput("protocol_error", int'(protocol_error), int'(modelErr));
        retireOk  = wbV && wbA != 0 && issuedCnt[wbA] > retiredCnt[wbA] &&
                    wbS == retiredCnt[wbA] % TAGS;
        retireBad = wbV && wbA != 0 && !retireOk;
        @(posedge clk);
        if (v && expReady && w && rd != 0) issuedCnt[rd]++;
        if (retireOk) retiredCnt[wbA]++;
        if (retireBad) modelErr = 1'b1;
        #1;
    endtask

    // Reset with junk traffic present, then measure the INIT window length.
    task automatic doReset();
        int cnt;
        cnt = 0;
        rst            = 1'b0;
        issue_valid    = 1'b1;
        issue_rd_write = 1'b1;
        issue_rd_addr  = 5'd5;
        issue_rs1_addr = 5'd5;
        issue_rs2_addr = 5'd5;
        wb_valid       = 1'b1;
        wb_addr        = 5'd3;
        wb_status      = 2'd2;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        while (cnt < 100) begin
            @(negedge clk);
            if (cnt == 4) begin
                checkOutput("init_rd_status", int'(issue_rd_status), 0);
                checkOutput("init_rs1_pending", int'(rs1_pending), 0);
                checkOutput("init_error", int'(protocol_error), 0);
                checkOutput("init_done_low", int'(init_done), 0);
            end
            if (issue_ready) break;
            cnt++;
            if (cnt == 20) begin
                issue_valid    = 1'b0;
                issue_rd_write = 1'b0;
                issue_rd_addr  = '0;
                issue_rs1_addr = '0;
                issue_rs2_addr = '0;
                wb_valid       = 1'b0;
                wb_addr        = '0;
                wb_status      = '0;
            end
        end
        checkOutput("init_cycles", cnt, 32);
        checkOutput("init_done_high", int'(init_done), 1);
        checkOutput("error_after_init", int'(protocol_error), 0);
        for (int r = 0; r < NR; r++) begin
            issuedCnt[r]  = 0;
            retiredCnt[r] = 0;
        end
        modelErr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Main sequence.
    initial begin
        int rd;
        int r;
        int wbA;
        int wbS;
        bit wbV;
        vectorCount    = 0;
        missCount      = 0;
        modelErr       = 1'b0;
        rst            = 1'b0;
        issue_valid    = 1'b0;
        issue_rd_write = 1'b0;
        issue_rd_addr  = '0;
        issue_rs1_addr = '0;
        issue_rs2_addr = '0;
        wb_valid       = 1'b0;
        wb_addr        = '0;
        wb_status      = '0;
        for (int i = 0; i < NR; i++) begin
            issuedCnt[i]  = 0;
            retiredCnt[i] = 0;
        end

        doReset();

        // Three issues to x5, then x5 seen pending, then in-order retires clear it.
        repeat (3) applyStimulus(1, 1, 5, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 5, 0, 0, 0, 0);
        for (int t = 0; t < 3; t++) applyStimulus(0, 0, 0, 5, 0, 1, 5, t);
        applyStimulus(0, 0, 0, 5, 5, 0, 0, 0);

        // Fill x7, stall, retire one, issue tag 3, then wrap back to tag 0.
        repeat (3) applyStimulus(1, 1, 7, 7, 0, 0, 0, 0);
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 7, 0, 0, 1, 7, 0);
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 7, 1);
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 0);

        // x0 as destination and source.
        repeat (10) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);

        // Same-cycle issue and retire on x9, with rd == rs1.
        applyStimulus(1, 1, 9, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 9, 9, 0, 1, 9, 0);
        applyStimulus(0, 0, 9, 9, 0, 0, 0, 0);
        applyStimulus(0, 0, 9, 0, 9, 1, 9, 1);

        // Full x11 stays stalled during the cycle its oldest tag retires.
        repeat (3) applyStimulus(1, 1, 11, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 11, 0, 11, 1, 11, 0);
        applyStimulus(1, 1, 11, 0, 11, 0, 0, 0);

        // Random legal traffic over a small register window.
        for (int n = 0; n < 600; n++) begin
            rd  = $urandom_range(0, 12);
            wbV = 1'b0;
            wbA = 0;
            wbS = 0;
            if ($urandom_range(0, 2) != 0) begin
                r = $urandom_range(0, 12);
                if (r == 0) begin
                    wbV = 1'b1;
                    wbS = $urandom_range(0, 3);
                end else if (issuedCnt[r] > retiredCnt[r]) begin
                    wbV = 1'b1;
                    wbA = r;
                    wbS = retiredCnt[r] % TAGS;
                end
            end
            applyStimulus(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0), rd,
                          $urandom_range(0, 12), $urandom_range(0, 12), wbV, wbA, wbS);
        end

        // Out-of-order retire on x4, then the legal one still works; then a spurious one.
        doReset();
        applyStimulus(1, 1, 4, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 4, 0, 1, 4, 1);
        applyStimulus(0, 0, 4, 4, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 4, 0, 1, 4, 0);
        applyStimulus(0, 0, 0, 4, 0, 1, 6, 0);
        repeat (2) applyStimulus(1, 1, 4, 4, 0, 0, 0, 0);

        // Mid-stream reset drops everything and restarts INIT.
        doReset();
        applyStimulus(0, 0, 4, 4, 7, 0, 0, 0);
        applyStimulus(1, 1, 7, 7, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
